// File: rtl/hack_bus_pkg.sv
// Shared constants and types for the Hack-side 16-bit routing blocks
// (dmux8way16, mux8way16_rr and later fan-in/fan-out stages).
package hack_bus_pkg;

    localparam int WIDTH = 16;
    localparam int NCH   = 8;
    localparam int SELW  = 3;

    typedef logic [SELW-1:0] chan_idx_t;

    // Successor of a channel index; the 3-bit width makes 7 wrap to 0.
    function automatic chan_idx_t next_idx(input chan_idx_t idx);
        return idx + chan_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: returns the first requesting channel
// found when scanning ptr, ptr+1, ..., ptr+7 (mod 8).
module rr_pick8
    import hack_bus_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic [2:0] grant,
    output logic       any
);

    chan_idx_t idx;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        grant = ptr;
        idx   = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + chan_idx_t'(k);
            if (req[idx]) begin
                grant = idx;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux8way16_rr.sv
// Eight-channel valid/ready gatherer: a round-robin arbiter selects one
// producer per transfer into a single registered output stage tagged with
// the source channel index.
module mux8way16_rr #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [NCH-1:0]   valid,
    output logic [NCH-1:0]   ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    import hack_bus_pkg::*;

    chan_idx_t        ptr;
    chan_idx_t        grant;
    logic             any;
    logic             load_ok;
    logic             xfer;
    logic [WIDTH-1:0] chdata [NCH];

    assign chdata[0] = a;
    assign chdata[1] = b;
    assign chdata[2] = c;
    assign chdata[3] = d;
    assign chdata[4] = e;
    assign chdata[5] = f;
    assign chdata[6] = g;
    assign chdata[7] = h;

    rr_pick8 u_pick (
        .req   (valid),
        .ptr   (ptr),
        .grant (grant),
        .any   (any)
    );

    // Handshake: the output stage can take a beat when empty or being drained,
    // and only the granted channel sees ready; reset masks every ack.
    always_comb begin
        load_ok = !out_valid || out_ready;
        xfer    = any && load_ok && !reset;
        ready   = '0;
        if (xfer) begin
            ready[grant] = 1'b1;
        end
    end

    // Output register and round-robin pointer; a held beat is dropped on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (any && load_ok) begin
            out       <= chdata[grant];
            out_sel   <= grant;
            out_valid <= 1'b1;
            ptr       <= next_idx(grant);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux8way16_rr.md
Name: mux8way16_rr

Overview:
- Gathering end of the 8-way 16-bit fan-out path: merges eight 16-bit producer channels (a..h) back onto one 16-bit stream.
- Each channel uses a valid/ready handshake.
- A round-robin arbiter picks one channel per transfer; the output is a single registered stage tagged with the source channel index.
- Sits downstream of dmux8way16-style routing, e.g. collecting results from eight lanes into one Hack-side consumer.

Parameters:
- WIDTH, 16, data width of every channel and of the output.
- NCH, 8, number of input channels. Fixed at 8; sel/index width is 3. Other values are not supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a..h  input  16 each  channel 0..7 data.
- valid  input  8  valid[i] = channel i presents data (bit 0 = a, bit 7 = h).
- ready  output  8  ready[i] = channel i's data is taken this cycle.
- out  output  16  registered output data.
- out_sel  output  3  index of the channel that produced out (0 = a ... 7 = h).
- out_valid  output  1  out/out_sel hold a beat.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (reset=1 at a clk edge):
  - out=0, out_sel=0, out_valid=0.
  - Round-robin pointer ptr=0.
  - ready=0 combinationally while reset is high.
  - Reset mid-transfer drops the held beat; no channel is acked that cycle.
- Output stage can load: load_ok = !out_valid || out_ready.
- Grant (combinational):
  - Scan channels ptr, ptr+1, ..., ptr+7 (mod 8).
  - grant = first index with valid set; any = |valid.
- ready[grant] = any && load_ok && !reset. All other ready bits are 0. At most one ready bit is high per cycle.
- On a transfer (any && load_ok):
  - out <= data of grant; out_sel <= grant; out_valid <= 1.
  - ptr <= grant+1 mod 8 (wraps 7 -> 0).
- Output consumed with no new transfer (out_valid && out_ready && !any): out_valid <= 0. out and out_sel keep their last values.
- Output held (out_valid && !out_ready):
  - out, out_sel, out_valid and ptr unchanged.
  - All ready bits are 0, which is backpressure on every channel.
- Simultaneous consume and load: full throughput, one beat per cycle, no bubble.
- Latency: channel data appears on out the cycle after its ready/valid handshake.
- Fairness: a continuously valid channel waits at most 7 transfers. With all 8 valid, grants rotate 0,1,...,7,0,...
- Channel data must be stable while valid is high and ready is low. A channel may drop valid before it is granted; it is then skipped with no side effects.
- No combinational path from out_ready to out. A path from out_ready to ready exists via load_ok and is intended.

Decomposition:
- Shared package hack_bus_pkg:
  - WIDTH=16, NCH=8, SELW=3 constants.
  - Channel index type (3-bit).
  - Reused by dmux8way16 and by future routing blocks.
- One sub-module, rr_pick8: combinational round-robin priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: grant[2:0], any.
  - Verified standalone.
- The top level holds the pointer, the output register and the handshake.

Test Plan:
- Reset check: reset=1 for 2 cycles with valid=8'hFF -> ready=0, out_valid=0, out=0, out_sel=0. After release, the first grant is channel 0 (ptr=0).
- Single channel: valid=8'b0000_1000, d=16'h0005, out_ready=1 -> ready=8'b0000_1000 in that cycle. Next cycle out=16'h0005, out_sel=3, out_valid=1. ptr becomes 4.
- Full rotation: all valid, a..h = 16'h0001..16'h0008, out_ready=1 held -> out_sel sequence 0,1,...,7,0 on consecutive cycles; out=16'h0001..0008 matching; no idle cycle.
- Wrap-around: ptr=7 (after granting g), valid=8'b1000_0001 -> h (sel 7) granted first, then a (sel 0); ptr goes 0 -> 1.
- Backpressure: out_valid=1 with out=16'h00AA, out_ready=0 for 3 cycles, valid=8'hFF -> out stable at 16'h00AA, ready=0 throughout. When out_ready rises, the next beat loads in that same cycle.
- Reset mid-operation: assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and ptr=0; the held beat is lost and no ready pulse is issued.
